// File: rtl/up_datapath_mc.sv
// Parametrised up_ datapath: register file, PC, SP, IR, flags and an ALU with
// iterative shift-add multiply and restoring divide behind a busy/done handshake.
module up_datapath_mc #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned RSW   = 2
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic [DW-1:0]  data_in,
  input  logic           a_sel_in_a,
  input  logic           a_sel_in_b,
  input  logic [3:0]     a_op,
  input  logic           a_start,
  input  logic           fl_we,
  input  logic           ir_we,
  input  logic           pc_we,
  input  logic           sp_we,
  input  logic           rb_we,
  input  logic [RSW-1:0] rb_sel_out_a,
  input  logic [RSW-1:0] rb_sel_out_b,
  input  logic [RSW:0]   rb_sel_in,
  output logic [DW-1:0]  data_out,
  output logic [3:0]     ir,
  output logic [3:0]     flags,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = $clog2(DW);

  localparam logic [3:0] OpAdd   = 4'h0;
  localparam logic [3:0] OpSub   = 4'h1;
  localparam logic [3:0] OpMul   = 4'h2;
  localparam logic [3:0] OpDiv   = 4'h3;
  localparam logic [3:0] OpNand  = 4'h4;
  localparam logic [3:0] OpNor   = 4'h5;
  localparam logic [3:0] OpXor   = 4'h6;
  localparam logic [3:0] OpPassB = 4'h7;
  localparam logic [3:0] OpAdc   = 4'h8;
  localparam logic [3:0] OpSbc   = 4'h9;
  localparam logic [3:0] OpShl   = 4'hA;
  localparam logic [3:0] OpShr   = 4'hB;

  logic [DW-1:0]   rf_q [NREGS];
  logic [DW-1:0]   pc_q, sp_q, opb_q;
  logic [3:0]      ir_q, flags_q, ir_nib;
  logic            busy_q, done_q, div_q;
  logic [2*DW-1:0] acc_q, acc_step;
  logic [CW-1:0]   cnt_q;

  logic [DW-1:0] op_a, op_b, alu_res;
  logic [DW:0]   ext, mul_sum, div_shift, div_diff;
  logic          alu_c, alu_v, cand_c, cand_v, cin, start_ok;

  assign op_a = a_sel_in_a ? rf_q[rb_sel_out_a] : sp_q;
  assign op_b = a_sel_in_b ? rf_q[rb_sel_out_b] : pc_q;
  assign cin  = flags_q[1];

  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (a_op)
      OpAdd, OpAdc: begin
        ext     = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, (a_op == OpAdc) & cin};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
        alu_v   = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      OpSub, OpSbc: begin
        // Bit DW of the extended difference is the borrow.
        ext     = {1'b0, op_a} - {1'b0, op_b} - {{DW{1'b0}}, (a_op == OpSbc) & cin};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
        alu_v   = (op_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      OpNand:  alu_res = ~(op_a & op_b);
      OpNor:   alu_res = ~(op_a | op_b);
      OpXor:   alu_res = op_a ^ op_b;
      OpPassB: alu_res = op_b;
      OpShl: begin
        alu_res = {op_a[DW-2:0], 1'b0};
        alu_c   = op_a[DW-1];
      end
      OpShr: begin
        alu_res = {1'b0, op_a[DW-1:1]};
        alu_c   = op_a[0];
      end
      default: ;
    endcase
  end

  // The done cycle presents the captured MUL/DIV result regardless of a_op.
  always_comb begin
    data_out = '0;
    cand_c   = 1'b0;
    cand_v   = 1'b0;
    if (busy_q) begin
      data_out = '0;
    end else if (done_q) begin
      data_out = acc_q[DW-1:0];
      cand_c   = ~div_q & (|acc_q[2*DW-1:DW]);
      cand_v   = div_q & ~(|opb_q);
    end else if (a_op != OpMul && a_op != OpDiv) begin
      data_out = alu_res;
      cand_c   = alu_c;
      cand_v   = alu_v;
    end
  end

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_q) begin
      acc_step = {mul_sum, acc_q[DW-1:1]};
    end else if (!div_diff[DW]) begin
      acc_step = {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[DW-1:0], acc_q[DW-2:0], 1'b0};
    end
  end

  if (DW >= 8) begin : g_ir_wide
    assign ir_nib = pc_q[0] ? data_in[7:4] : data_in[3:0];
  end else begin : g_ir_narrow
    // Narrow data words carry only one instruction nibble.
    assign ir_nib = data_in[3:0];
  end

  assign start_ok = a_start & ~busy_q & ~done_q & ((a_op == OpMul) | (a_op == OpDiv));

  always_ff @(posedge clk) begin
    if (!nRst) begin
      pc_q    <= '0;
      sp_q    <= '1;
      ir_q    <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= DW'(i + 1);
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        div_q  <= (a_op == OpDiv);
        opb_q  <= op_b;
        acc_q  <= {{DW{1'b0}}, op_a};
      end else if (busy_q) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
      if (ir_we) ir_q <= ir_nib;
      if (pc_we && !busy_q) pc_q <= data_out;
      if (sp_we && !busy_q) sp_q <= data_out;
      if (fl_we && !busy_q) flags_q <= {data_out[DW-1], cand_v, cand_c, ~(|data_out)};
      if (rb_we && !(busy_q && rb_sel_in[RSW])) begin
        rf_q[rb_sel_in[RSW-1:0]] <= rb_sel_in[RSW] ? data_out : data_in;
      end
    end
  end

  assign ir    = ir_q;
  assign flags = flags_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_up_datapath_mc.sv
// Self-checking bench for up_datapath_mc: randomized ALU traffic against an
// arithmetic reference model, MUL/DIV handshake, reset abort and a DW=16 instance.
module tb_up_datapath_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       nRst, a_sel_in_a, a_sel_in_b, a_start, fl_we, ir_we, pc_we, sp_we, rb_we;
  logic [7:0] data_in, data_out;
  logic [3:0] a_op, ir, flags;
  logic [1:0] rb_sel_out_a, rb_sel_out_b;
  logic [2:0] rb_sel_in;
  logic       busy, done;

  logic        w_nRst, w_a_sel_in_a, w_a_sel_in_b, w_a_start, w_fl_we, w_ir_we;
  logic        w_pc_we, w_sp_we, w_rb_we, w_busy, w_done;
  logic [15:0] w_data_in, w_data_out;
  logic [3:0]  w_a_op, w_ir, w_flags, w_rb_sel_in;
  logic [2:0]  w_rb_sel_out_a, w_rb_sel_out_b;

  up_datapath_mc #(.DW(8), .NREGS(4), .RSW(2)) dut (
    .clk(clk), .nRst(nRst), .data_in(data_in), .a_sel_in_a(a_sel_in_a),
    .a_sel_in_b(a_sel_in_b), .a_op(a_op), .a_start(a_start), .fl_we(fl_we),
    .ir_we(ir_we), .pc_we(pc_we), .sp_we(sp_we), .rb_we(rb_we),
    .rb_sel_out_a(rb_sel_out_a), .rb_sel_out_b(rb_sel_out_b), .rb_sel_in(rb_sel_in),
    .data_out(data_out), .ir(ir), .flags(flags), .busy(busy), .done(done)
  );

  up_datapath_mc #(.DW(16), .NREGS(8), .RSW(3)) dut_w (
    .clk(clk), .nRst(w_nRst), .data_in(w_data_in), .a_sel_in_a(w_a_sel_in_a),
    .a_sel_in_b(w_a_sel_in_b), .a_op(w_a_op), .a_start(w_a_start), .fl_we(w_fl_we),
    .ir_we(w_ir_we), .pc_we(w_pc_we), .sp_we(w_sp_we), .rb_we(w_rb_we),
    .rb_sel_out_a(w_rb_sel_out_a), .rb_sel_out_b(w_rb_sel_out_b), .rb_sel_in(w_rb_sel_in),
    .data_out(w_data_out), .ir(w_ir), .flags(w_flags), .busy(w_busy), .done(w_done)
  );

  // Reference state of the DW=8 instance.
  int         m_reg [4];
  logic [3:0] m_flags;
  int         m_pc;

  // Returns {n,v,c,z,result} computed with plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input int op, input int a, input int b, input int cin);
    int r, sa, sb, sr, k;
    logic c, v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 1'b0; v = 1'b0; r = 0; sr = 0;
    k = (op == 8 || op == 9) ? cin : 0;
    case (op)
      0, 8: begin
        r = a + b + k; c = (r > 255);
        sr = sa + sb + k; v = (sr > 127) || (sr < -128);
      end
      1, 9: begin
        r = a - b - k; c = (a < b + k);
        sr = sa - sb - k; v = (sr > 127) || (sr < -128);
      end
      4: r = 255 - (a & b);
      5: r = 255 - (a | b);
      6: r = a ^ b;
      7: r = b;
      10: begin r = a * 2; c = (a > 127); end
      11: begin r = a / 2; c = (a % 2 == 1); end
      default: r = 0;
    endcase
    r = r & 255;
    return {(r > 127), v, c, (r == 0), 8'(r)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_start = 0; fl_we = 0; ir_we = 0; pc_we = 0; sp_we = 0; rb_we = 0;
    a_op = 4'h7; a_sel_in_a = 1; a_sel_in_b = 1;
    rb_sel_out_a = 0; rb_sel_out_b = 1; rb_sel_in = 0; data_in = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = i + 1;
    m_flags = 4'h0;
    m_pc = 0;
  endtask

  task automatic load_reg(input int idx, input int val);
    data_in = val[7:0];
    rb_sel_in = {1'b0, idx[1:0]};
    rb_we = 1;
    step();
    rb_we = 0;
    m_reg[idx] = val;
  endtask

  task automatic test_reset();
    idle();
    nRst = 0;
    step(); step();
    nRst = 1;
    model_reset();
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", flags); end
    if (ir !== 4'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", ir); end
    a_op = 4'h7; a_sel_in_b = 0; #1;
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", data_out); end
    a_op = 4'h6; a_sel_in_a = 0; #1;
    n_checks++;
    if (data_out !== 8'hFF) begin n_fail++; $display("FAIL reset_sp: got %h want ff", data_out); end
    a_op = 4'h7; a_sel_in_a = 1; a_sel_in_b = 1;
    for (int i = 0; i < 4; i++) begin
      rb_sel_out_b = i[1:0]; #1;
      n_checks++;
      if (data_out !== 8'(i + 1)) begin
        n_fail++; $display("FAIL reset_r%0d: got %h want %h", i, data_out, 8'(i + 1));
      end
    end
    idle();
  endtask

  task automatic test_add_flags();
    load_reg(0, 8'h7F); load_reg(1, 8'h01);
    a_op = 4'h0; rb_sel_out_a = 0; rb_sel_out_b = 1; fl_we = 1; #1;
    n_checks++;
    if (data_out !== 8'h80) begin n_fail++; $display("FAIL add_result: got %h want 80", data_out); end
    step(); fl_we = 0;
    n_checks++;
    if (flags !== 4'b1100) begin n_fail++; $display("FAIL add_flags: got %b want 1100", flags); end
    load_reg(0, 8'h00); load_reg(1, 8'h01);
    a_op = 4'h9; fl_we = 1; #1;
    n_checks++;
    if (data_out !== 8'hFF) begin n_fail++; $display("FAIL sbc_result: got %h want ff", data_out); end
    step(); fl_we = 0;
    n_checks++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL sbc_flags: got %b want 1010", flags); end
    m_flags = 4'b1010;
    idle();
  endtask

  task automatic test_random_alu();
    int ops [12] = '{0, 1, 4, 5, 6, 7, 8, 9, 10, 11, 12, 15};
    int a, b, op;
    logic [11:0] exp;
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      op = ops[$urandom_range(0, 11)];
      load_reg(0, a); load_reg(1, b);
      a_sel_in_a = 1; a_sel_in_b = 1; rb_sel_out_a = 0; rb_sel_out_b = 1;
      a_op = op[3:0]; fl_we = 1;
      exp = ref_alu(op, a, b, int'(m_flags[1]));
      #1;
      n_checks++;
      if (data_out !== exp[7:0]) begin
        n_fail++; $display("FAIL alu_op%0d(%h,%h): got %h want %h", op, a, b, data_out, exp[7:0]);
      end
      step(); fl_we = 0;
      n_checks++;
      if (flags !== exp[11:8]) begin
        n_fail++; $display("FAIL alu_flags_op%0d(%h,%h): got %b want %b", op, a, b, flags, exp[11:8]);
      end
      m_flags = exp[11:8];
    end
    idle();
  endtask

  // One MUL (op 2) or DIV (op 3) run with protected write enables held during busy.
  task automatic test_muldiv(input int op, input int a, input int b);
    int n, p, res;
    logic c, v;
    logic [3:0] exp_fl;
    if (op == 2) begin
      p = a * b; res = p & 255; c = (p > 255); v = 1'b0;
    end else begin
      res = (b == 0) ? 255 : a / b; c = 1'b0; v = (b == 0);
    end
    exp_fl = {(res > 127), v, c, (res == 0)};
    load_reg(0, a); load_reg(1, b);
    a_sel_in_a = 1; a_sel_in_b = 1; rb_sel_out_a = 0; rb_sel_out_b = 1;
    a_op = op[3:0]; a_start = 1; #1;
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL md_idle_out: got %h want 00", data_out); end
    step();
    a_start = 0; a_op = 4'h7;
    pc_we = 1; sp_we = 1; fl_we = 1; rb_we = 1; rb_sel_in = 3'b110;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL md_busy_out: got %h want 00", data_out); end
      n++;
      step();
    end
    pc_we = 0; sp_we = 0; rb_sel_in = 3'b111;
    n_checks += 3;
    if (n !== 8) begin n_fail++; $display("FAIL md_busy_len: got %0d want 8", n); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL md_done: got %b want 1", done); end
    if (flags !== m_flags) begin n_fail++; $display("FAIL md_flags_held: got %b want %b", flags, m_flags); end
    #1;
    n_checks++;
    if (data_out !== 8'(res)) begin
      n_fail++; $display("FAIL md_op%0d(%0d,%0d): got %h want %h", op, a, b, data_out, 8'(res));
    end
    step();
    fl_we = 0; rb_we = 0;
    m_flags = exp_fl; m_reg[3] = res;
    n_checks += 2;
    if (done !== 1'b0) begin n_fail++; $display("FAIL md_done_pulse: got %b want 0", done); end
    if (flags !== exp_fl) begin n_fail++; $display("FAIL md_flags: got %b want %b", flags, exp_fl); end
    rb_sel_out_b = 3; #1;
    n_checks++;
    if (data_out !== 8'(res)) begin n_fail++; $display("FAIL md_wb_r3: got %h want %h", data_out, 8'(res)); end
    rb_sel_out_b = 2; #1;
    n_checks++;
    if (data_out !== 8'(m_reg[2])) begin
      n_fail++; $display("FAIL md_r2_held: got %h want %h", data_out, 8'(m_reg[2]));
    end
    a_sel_in_b = 0; #1;
    n_checks++;
    if (data_out !== 8'(m_pc)) begin n_fail++; $display("FAIL md_pc_held: got %h want %h", data_out, 8'(m_pc)); end
    idle();
  endtask

  task automatic test_mul();
    load_reg(2, 8'h33);
    a_op = 4'h7; a_sel_in_b = 1; rb_sel_out_b = 2; pc_we = 1;
    step();
    pc_we = 0; m_pc = 8'h33;
    idle();
    test_muldiv(2, 13, 11);
    test_muldiv(2, 20, 20);
    for (int i = 0; i < 3; i++) test_muldiv(2, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic test_div();
    test_muldiv(3, 200, 7);
    test_muldiv(3, 5, 0);
    for (int i = 0; i < 3; i++) test_muldiv(3, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic test_start_ignore();
    int n, extra;
    a_op = 4'h7; a_start = 1;
    step();
    a_start = 0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_bad_op: got busy %b want 0", busy); end
    load_reg(0, 200); load_reg(1, 7);
    a_op = 4'h3; a_start = 1;
    step();
    a_op = 4'h2; n = 0;
    while (busy === 1'b1 && n < 40) begin
      a_start = (n == 2 || n == 5);
      n++;
      step();
    end
    a_start = 0; #1;
    n_checks += 3;
    if (n !== 8) begin n_fail++; $display("FAIL restart_busy_len: got %0d want 8", n); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", done); end
    if (data_out !== 8'h1C) begin n_fail++; $display("FAIL restart_result: got %h want 1c", data_out); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL restart_extra: got %0d want 0", extra); end
    idle();
  endtask

  task automatic test_back_to_back();
    int n;
    load_reg(0, 3); load_reg(1, 5);
    a_op = 4'h2; a_start = 1;
    step();
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(); end
    #1;
    n_checks++;
    if (data_out !== 8'd15) begin n_fail++; $display("FAIL b2b_first: got %h want 0f", data_out); end
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start: got busy %b want 0", busy); end
    step();
    a_start = 0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(); end
    #1;
    n_checks += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", done); end
    if (data_out !== 8'd15) begin n_fail++; $display("FAIL b2b_second: got %h want 0f", data_out); end
    idle();
  endtask

  task automatic test_reset_abort();
    int dones;
    load_reg(0, 13); load_reg(1, 11);
    a_op = 4'h2; a_start = 1;
    step();
    a_start = 0;
    step(); step(); step();
    nRst = 0;
    step();
    nRst = 1;
    model_reset();
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_late_done: got %0d want 0", dones); end
    idle();
  endtask

  task automatic test_ir();
    data_in = 8'hA5; ir_we = 1;
    step();
    ir_we = 0;
    n_checks++;
    if (ir !== 4'h5) begin n_fail++; $display("FAIL ir_even: got %h want 5", ir); end
    a_op = 4'h7; a_sel_in_b = 1; rb_sel_out_b = 0; pc_we = 1;
    step();
    pc_we = 0; m_pc = m_reg[0];
    data_in = 8'hA5; ir_we = 1;
    step();
    ir_we = 0;
    n_checks++;
    if (ir !== 4'hA) begin n_fail++; $display("FAIL ir_odd: got %h want a", ir); end
    idle();
  endtask

  task automatic test_forward();
    a_op = 4'h7; a_sel_in_b = 1; rb_sel_out_b = 2;
    data_in = 8'h5A; rb_sel_in = 3'b010; rb_we = 1; #1;
    n_checks++;
    if (data_out !== 8'(m_reg[2])) begin
      n_fail++; $display("FAIL fwd_old: got %h want %h", data_out, 8'(m_reg[2]));
    end
    step();
    rb_we = 0; m_reg[2] = 8'h5A; #1;
    n_checks++;
    if (data_out !== 8'h5A) begin n_fail++; $display("FAIL fwd_new: got %h want 5a", data_out); end
    idle();
  endtask

  task automatic test_param();
    int lat;
    w_nRst = 0;
    step(); step();
    w_nRst = 1;
    w_a_op = 4'h7; w_a_sel_in_b = 1; w_rb_sel_out_b = 7; #1;
    n_checks++;
    if (w_data_out !== 16'd8) begin n_fail++; $display("FAIL w_r7_reset: got %h want 0008", w_data_out); end
    w_data_in = 16'd300; w_rb_sel_in = 4'd0; w_rb_we = 1;
    step();
    w_rb_sel_in = 4'd1;
    step();
    w_rb_we = 0;
    w_a_sel_in_a = 1; w_a_sel_in_b = 1; w_rb_sel_out_a = 0; w_rb_sel_out_b = 1;
    w_a_op = 4'h2; w_a_start = 1;
    step();
    w_a_start = 0;
    lat = 1;
    while (w_busy === 1'b1 && lat < 60) begin lat++; step(); end
    w_fl_we = 1; #1;
    n_checks += 3;
    if (lat !== 17) begin n_fail++; $display("FAIL w_latency: got %0d want 17", lat); end
    if (w_done !== 1'b1) begin n_fail++; $display("FAIL w_done: got %b want 1", w_done); end
    if (w_data_out !== 16'h5F90) begin n_fail++; $display("FAIL w_mul: got %h want 5f90", w_data_out); end
    step();
    w_fl_we = 0;
    n_checks++;
    if (w_flags !== 4'b0010) begin n_fail++; $display("FAIL w_flags: got %b want 0010", w_flags); end
  endtask

  initial begin
    nRst = 0;
    idle();
    w_nRst = 0; w_data_in = 0; w_a_sel_in_a = 1; w_a_sel_in_b = 1; w_a_op = 4'h7;
    w_a_start = 0; w_fl_we = 0; w_ir_we = 0; w_pc_we = 0; w_sp_we = 0; w_rb_we = 0;
    w_rb_sel_out_a = 0; w_rb_sel_out_b = 0; w_rb_sel_in = 0;
    model_reset();
    test_reset();
    test_add_flags();
    test_random_alu();
    test_mul();
    test_div();
    test_start_ignore();
    test_back_to_back();
    test_reset_abort();
    test_ir();
    test_forward();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
